// File: rtl/gpio_port_ctrl_if.sv
// gpio_port_ctrl_if: register-access bus between the SPI register logic and
// the GPIO bank controller.
//   wr_en    - write strobe, one cycle per write
//   rd_en    - read strobe, one cycle per read
//   addr     - 3-bit register address
//   wdata    - write data
//   rdata    - read data, valid while rd_valid=1
//   rd_valid - one-cycle pulse, one cycle after rd_en
// master: register-access side; slave: gpio_port_ctrl.
interface gpio_port_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             wr_en;
    logic             rd_en;
    logic [2:0]       addr;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata;
    logic             rd_valid;

    modport master (
        output wr_en, rd_en, addr, wdata,
        input  rdata, rd_valid
    );

    modport slave (
        input  wr_en, rd_en, addr, wdata,
        output rdata, rd_valid
    );
endinterface

// File: rtl/gpio_port_ctrl.sv
// gpio_port_ctrl: core-side controller for a bank of WIDTH GPIO pads.
// Holds OUT/OE/PU/PD control registers, synchronizes pad receiver outputs,
// and flags selected edges into sticky, maskable interrupt status bits.
// Ports:
//   clk, rst_n - clock (rising edge), asynchronous active-low reset
//   bus        - register access (wr_en, rd_en, addr, wdata, rdata, rd_valid)
//   pad_a      - driver data (OUT)
//   pad_oe     - driver enable (OE)
//   pad_pu     - pull-up enable (PU & ~PD)
//   pad_pd     - pull-down enable (PD)
//   pad_y      - asynchronous receiver outputs from the pads
//   irq        - registered level interrupt, |(IRQ_STAT & IRQ_EN)
// Register map: 0 OUT, 1 OE, 2 PU, 3 PD, 4 IN (ro), 5 IRQ_EN,
//               6 IRQ_STAT (W1C), 7 EDGE_SEL (1 = rising, 0 = falling)
module gpio_port_ctrl #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    gpio_port_ctrl_if.slave        bus,
    output logic [WIDTH-1:0]       pad_a,
    output logic [WIDTH-1:0]       pad_oe,
    output logic [WIDTH-1:0]       pad_pu,
    output logic [WIDTH-1:0]       pad_pd,
    input  logic [WIDTH-1:0]       pad_y,
    output logic                   irq
);
    localparam int unsigned NSYNC       = SYNC_STAGES;
    localparam int unsigned WARM_CYCLES = SYNC_STAGES + 1;
    localparam int unsigned CW          = $clog2(WARM_CYCLES + 1);

    localparam logic [2:0] ADDR_OUT      = 3'd0;
    localparam logic [2:0] ADDR_OE       = 3'd1;
    localparam logic [2:0] ADDR_PU       = 3'd2;
    localparam logic [2:0] ADDR_PD       = 3'd3;
    localparam logic [2:0] ADDR_IN       = 3'd4;
    localparam logic [2:0] ADDR_IRQ_EN   = 3'd5;
    localparam logic [2:0] ADDR_IRQ_STAT = 3'd6;
    localparam logic [2:0] ADDR_EDGE_SEL = 3'd7;

    logic [WIDTH-1:0] out_q, oe_q, pu_q, pd_q;
    logic [WIDTH-1:0] irq_en_q, edge_sel_q;
    logic [WIDTH-1:0] irq_stat_q, irq_stat_d;
    logic [WIDTH-1:0] sync_q [NSYNC];
    logic [WIDTH-1:0] prev_q;
    logic [CW-1:0]    warm_q, warm_d;
    logic [WIDTH-1:0] rdata_q, rdata_d;
    logic             rd_valid_q;
    logic             irq_q;

    logic [WIDTH-1:0] in_w, rise_w, fall_w, edge_hit_w, w1c_w;
    logic             warm_done_w;

    assign in_w        = sync_q[NSYNC-1];
    assign warm_done_w = (warm_q == CW'(WARM_CYCLES));

    always_comb begin
        rise_w     = in_w & ~prev_q;
        fall_w     = ~in_w & prev_q;
        // Warm-up hides the 0 -> pad transition of the freshly reset chain.
        edge_hit_w = '0;
        if (warm_done_w) begin
            edge_hit_w = (rise_w & edge_sel_q) | (fall_w & ~edge_sel_q);
        end
        w1c_w = '0;
        if (bus.wr_en && (bus.addr == ADDR_IRQ_STAT)) begin
            w1c_w = bus.wdata;
        end
        // Set after clear: a new edge wins over a simultaneous W1C.
        irq_stat_d = (irq_stat_q & ~w1c_w) | edge_hit_w;
        warm_d     = warm_done_w ? warm_q : warm_q + 1'b1;
    end

    // Reads sample the current flop values, so a same-cycle write is not seen.
    always_comb begin
        rdata_d = rdata_q;
        if (bus.rd_en) begin
            case (bus.addr)
                ADDR_OUT:      rdata_d = out_q;
                ADDR_OE:       rdata_d = oe_q;
                ADDR_PU:       rdata_d = pu_q;
                ADDR_PD:       rdata_d = pd_q;
                ADDR_IN:       rdata_d = in_w;
                ADDR_IRQ_EN:   rdata_d = irq_en_q;
                ADDR_IRQ_STAT: rdata_d = irq_stat_q;
                ADDR_EDGE_SEL: rdata_d = edge_sel_q;
                default:       rdata_d = rdata_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q      <= '0;
            oe_q       <= '0;
            pu_q       <= '0;
            pd_q       <= '0;
            irq_en_q   <= '0;
            edge_sel_q <= '0;
        end else if (bus.wr_en) begin
            case (bus.addr)
                ADDR_OUT:      out_q      <= bus.wdata;
                ADDR_OE:       oe_q       <= bus.wdata;
                ADDR_PU:       pu_q       <= bus.wdata;
                ADDR_PD:       pd_q       <= bus.wdata;
                ADDR_IRQ_EN:   irq_en_q   <= bus.wdata;
                ADDR_EDGE_SEL: edge_sel_q <= bus.wdata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NSYNC; i++) begin
                sync_q[i] <= '0;
            end
            prev_q     <= '0;
            warm_q     <= '0;
            irq_stat_q <= '0;
            rdata_q    <= '0;
            rd_valid_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            sync_q[0] <= pad_y;
            for (int unsigned i = 1; i < NSYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q     <= in_w;
            warm_q     <= warm_d;
            irq_stat_q <= irq_stat_d;
            rdata_q    <= rdata_d;
            rd_valid_q <= bus.rd_en;
            irq_q      <= |(irq_stat_q & irq_en_q);
        end
    end

    assign bus.rdata    = rdata_q;
    assign bus.rd_valid = rd_valid_q;
    assign pad_a        = out_q;
    assign pad_oe       = oe_q;
    assign pad_pu       = pu_q & ~pd_q;
    assign pad_pd       = pd_q;
    assign irq          = irq_q;
endmodule

// File: doc/gpio_port_ctrl.md
Name: gpio_port_ctrl

Overview:
Core-side controller for a bank of WIDTH GPIO pads. It holds the per-pin output, output-enable and pull-up/pull-down control registers, and drives the pads' a/oe/pu/pd inputs. It synchronizes the pads' receiver outputs (y) into the clock domain and performs edge detection with maskable, sticky interrupt flags. It sits between the SPI register-access logic and the pad ring.

Parameters:
WIDTH, 8, number of GPIO pins in the bank
SYNC_STAGES, 2, flops in each input synchronizer chain (legal range 2..4)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
wr_en  input  1  register write strobe, one cycle per write
rd_en  input  1  register read strobe, one cycle per read
addr  input  3  register address
wdata  input  WIDTH  write data
rdata  output  WIDTH  read data, valid when rd_valid=1
rd_valid  output  1  one-cycle pulse, one cycle after rd_en
pad_a  output  WIDTH  per-pin driver data, to pad a
pad_oe  output  WIDTH  per-pin driver enable, to pad oe
pad_pu  output  WIDTH  per-pin pull-up enable, to pad pu
pad_pd  output  WIDTH  per-pin pull-down enable, to pad pd
pad_y  input  WIDTH  per-pin receiver outputs from pads, asynchronous
irq  output  1  level interrupt, registered

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset values: all registers, synchronizer flops, rdata, rd_valid and irq are 0. Pads come up undriven with no pulls.
- Register map:
  - 0 OUT (rw)
  - 1 OE (rw)
  - 2 PU (rw)
  - 3 PD (rw)
  - 4 IN (ro, synchronized pad value)
  - 5 IRQ_EN (rw)
  - 6 IRQ_STAT (read, write-1-to-clear)
  - 7 EDGE_SEL (rw; bit 1 = rising edge, bit 0 = falling edge)
- Writes take effect at the clock edge on which wr_en=1.
- Writes to addr 4 are ignored. A write to addr 6 clears the bits where wdata=1.
- pad_a=OUT and pad_oe=OE are driven straight from the flops, so they change one cycle after the write.
- pad_pu = PU & ~PD and pad_pd = PD: pull-down has priority, and pu and pd are never both 1 on any pin.
- Reads: on rd_en, the value at addr is registered into rdata and rd_valid pulses on the next cycle. rdata holds its value until the next read.
- If rd_en and wr_en hit the same address in the same cycle, the read returns the pre-write value.
- Synchronizer: pad_y passes through SYNC_STAGES flops per bit; the last stage is IN. A stable pad change is visible in IN after exactly SYNC_STAGES clocks.
- Edge detect: a prev flop holds the last cycle's IN. A rising edge on bit i is IN[i]&~prev[i]; a falling edge is ~IN[i]&prev[i]. The edge polarity used is selected per bit by EDGE_SEL.
- Interrupt flags: a selected edge sets IRQ_STAT[i] on the next clock, i.e. SYNC_STAGES+1 clocks after the pad change. IRQ_STAT bits are sticky; edges are latched regardless of IRQ_EN.
- Simultaneous W1C and new edge on the same bit in the same cycle: set wins and the bit stays 1.
- Warm-up: after reset deasserts, a counter suppresses edge detection for SYNC_STAGES+1 cycles. This prevents the 0-reset chain from flagging spurious rising edges on pins that are high at reset.
- irq is registered as irq = |(IRQ_STAT & IRQ_EN), so it follows flag or enable changes by one clock.
- Reset mid-operation clears everything immediately, including pending flags and a read in progress (rd_valid forced 0).
- Pulses on pad_y shorter than one clock period may be missed; this is acceptable and not flagged.

Test Plan:
1. Reset with pad_y=8'hFF held, WIDTH=8, SYNC_STAGES=2 -> IN reads 8'hFF after 2 clocks; IRQ_STAT stays 8'h00 through warm-up with EDGE_SEL=8'hFF; irq=0.
2. Write OUT=8'hA5, OE=8'h0F -> pad_a=8'hA5 and pad_oe=8'h0F one clock after wr_en; read addr 0 -> rdata=8'hA5 with rd_valid one clock after rd_en.
3. Write PU=8'hFF, PD=8'h0F -> pad_pu=8'hF0 and pad_pd=8'h0F; at no time are pu and pd both 1 on a pin.
4. Set EDGE_SEL=8'h01, IRQ_EN=8'h03; drive pad_y bit0 0->1 and bit1 1->0 -> IRQ_STAT=8'h03 exactly 3 clocks after the change; irq=1 one clock later.
5. Write addr 6 with 8'h01 -> IRQ_STAT=8'h02 and irq stays 1. Then W1C 8'h02 in the same cycle as a new bit1 falling edge -> bit1 remains 1.
6. Assert rst_n=0 mid-sequence with IRQ_STAT=8'h03 and irq=1 -> all outputs 0 asynchronously; after release, warm-up suppresses edges for 3 cycles.
